// File: rtl/capture_ctrl.sv
// Capture sequencer: arms on the SPI arm level, waits for an external trigger
// (or auto-trigger timeout), then gates exactly CAPTURE_WORDS write beats into main memory.
module capture_ctrl #(
    parameter int CAPTURE_WORDS = 1024,
    parameter int CNT_WIDTH     = 16,
    parameter int TRIG_TIMEOUT  = 0
) (
    input  logic                 capture_ctrl_clk,
    input  logic                 capture_ctrl_reset_n,
    input  logic                 capture_ctrl_system_ready,
    input  logic                 capture_ctrl_arm,
    input  logic                 capture_ctrl_ext_trig,
    input  logic                 capture_ctrl_ext_trig_en,
    input  logic                 capture_ctrl_data_en,
    input  logic                 capture_ctrl_fifo_full,
    output logic                 capture_ctrl_wr_en,
    output logic                 capture_ctrl_busy,
    output logic                 capture_ctrl_done,
    output logic                 capture_ctrl_overflow,
    output logic                 capture_ctrl_timed_out,
    output logic [CNT_WIDTH-1:0] capture_ctrl_word_count,
    output logic [2:0]           capture_ctrl_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TRIG = 3'd1,
        CAPTURE   = 3'd2,
        DONE      = 3'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(CAPTURE_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] TO_IDX   = CNT_WIDTH'((TRIG_TIMEOUT > 0) ? TRIG_TIMEOUT - 1 : 0);
    localparam bit                   TO_EN    = (TRIG_TIMEOUT != 0);

    state_t               state_q;
    logic                 arm_s1, arm_s2, arm_prev;
    logic                 trig_s1, trig_s2, trig_prev;
    logic [CNT_WIDTH-1:0] tcnt;
    logic [CNT_WIDTH-1:0] word_count_q;
    logic                 busy_q, done_q, overflow_q, timed_out_q;

    logic arm_rise, arm_fall, trig_rise, beat, timeout_hit, abort;

    always_ff @(posedge capture_ctrl_clk or negedge capture_ctrl_reset_n) begin
        if (!capture_ctrl_reset_n) begin
            arm_s1    <= 1'b0;
            arm_s2    <= 1'b0;
            arm_prev  <= 1'b0;
            trig_s1   <= 1'b0;
            trig_s2   <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            arm_s1    <= capture_ctrl_arm;
            arm_s2    <= arm_s1;
            arm_prev  <= arm_s2;
            trig_s1   <= capture_ctrl_ext_trig;
            trig_s2   <= trig_s1;
            trig_prev <= trig_s2;
        end
    end

    assign arm_rise    = arm_s2 & ~arm_prev;
    assign arm_fall    = ~arm_s2 & arm_prev;
    assign trig_rise   = trig_s2 & ~trig_prev;
    assign timeout_hit = TO_EN && (tcnt == TO_IDX);
    assign abort       = ~capture_ctrl_system_ready | arm_fall;

    // Combinational from registered state so the beat stays aligned with its data.
    assign beat = (state_q == CAPTURE) & capture_ctrl_data_en & ~capture_ctrl_fifo_full
                  & capture_ctrl_system_ready;

    always_ff @(posedge capture_ctrl_clk or negedge capture_ctrl_reset_n) begin
        if (!capture_ctrl_reset_n) begin
            state_q      <= IDLE;
            tcnt         <= '0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            if (state_q == CAPTURE && capture_ctrl_data_en && capture_ctrl_fifo_full)
                overflow_q <= 1'b1;
            if (beat)
                word_count_q <= word_count_q + CNT_WIDTH'(1);

            case (state_q)
                IDLE: begin
                    if (capture_ctrl_system_ready && arm_rise) begin
                        state_q      <= WAIT_TRIG;
                        busy_q       <= 1'b1;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                        timed_out_q  <= 1'b0;
                        tcnt         <= '0;
                    end
                end
                WAIT_TRIG: begin
                    tcnt <= tcnt + CNT_WIDTH'(1);
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (!capture_ctrl_ext_trig_en || trig_rise) begin
                        state_q <= CAPTURE;
                    end else if (timeout_hit) begin
                        state_q     <= CAPTURE;
                        timed_out_q <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (beat && word_count_q == LAST_IDX) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign capture_ctrl_wr_en      = beat;
    assign capture_ctrl_busy       = busy_q;
    assign capture_ctrl_done       = done_q;
    assign capture_ctrl_overflow   = overflow_q;
    assign capture_ctrl_timed_out  = timed_out_q;
    assign capture_ctrl_word_count = word_count_q;
    assign capture_ctrl_state      = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed test-plan scenarios plus randomized episodes,
// every cycle compared against a behavioural model of the capture sequencer.
module tb_capture_ctrl;

    localparam int N_WORDS = 8;
    localparam int T_OUT   = 20;
    localparam int CW      = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          system_ready = 1'b0;
    logic          arm = 1'b0;
    logic          ext_trig = 1'b0;
    logic          ext_trig_en = 1'b0;
    logic          data_en = 1'b0;
    logic          fifo_full = 1'b0;
    logic          wr_en, busy, done, overflow, timed_out;
    logic [CW-1:0] word_count;
    logic [2:0]    state;

    int tests = 0;
    int fails = 0;

    capture_ctrl #(.CAPTURE_WORDS(N_WORDS), .CNT_WIDTH(CW), .TRIG_TIMEOUT(T_OUT)) dut (
        .capture_ctrl_clk(clk),
        .capture_ctrl_reset_n(rst_n),
        .capture_ctrl_system_ready(system_ready),
        .capture_ctrl_arm(arm),
        .capture_ctrl_ext_trig(ext_trig),
        .capture_ctrl_ext_trig_en(ext_trig_en),
        .capture_ctrl_data_en(data_en),
        .capture_ctrl_fifo_full(fifo_full),
        .capture_ctrl_wr_en(wr_en),
        .capture_ctrl_busy(busy),
        .capture_ctrl_done(done),
        .capture_ctrl_overflow(overflow),
        .capture_ctrl_timed_out(timed_out),
        .capture_ctrl_word_count(word_count),
        .capture_ctrl_state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode: 0 idle, 1 waiting for trigger, 2 capturing, 3 done.
    // Edges are seen two clocks late; a rise at edge j uses samples from edges j-2 and j-3.
    int m_mode, m_cnt, m_wait;
    bit m_ovf, m_to;
    bit arm_h[$];
    bit trig_h[$];

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_wait = 0; m_ovf = 0; m_to = 0;
        arm_h  = '{1'b0, 1'b0, 1'b0};
        trig_h = '{1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_step();
        bit a_rise, a_fall, t_rise, wr;
        int nxt;
        a_rise = arm_h[1] && !arm_h[0];
        a_fall = !arm_h[1] && arm_h[0];
        t_rise = trig_h[1] && !trig_h[0];
        wr     = (m_mode == 2) && data_en && !fifo_full && system_ready;
        nxt    = m_mode;
        if (m_mode == 2 && data_en && fifo_full) m_ovf = 1;
        if (wr) m_cnt++;
        if (m_mode == 0) begin
            if (system_ready && a_rise) begin
                nxt = 1; m_cnt = 0; m_ovf = 0; m_to = 0; m_wait = 0;
            end
        end else if (!system_ready || a_fall) begin
            nxt = 0;
        end else if (m_mode == 1) begin
            m_wait++;
            if (!ext_trig_en || t_rise) nxt = 2;
            else if (T_OUT != 0 && m_wait == T_OUT) begin
                nxt = 2; m_to = 1;
            end
        end else if (m_mode == 2) begin
            if (wr && m_cnt == N_WORDS) nxt = 3;
        end
        m_mode = nxt;
        arm_h.push_back(arm);    void'(arm_h.pop_front());
        trig_h.push_back(ext_trig); void'(trig_h.pop_front());
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Compare process: inputs change 2 units after the rising edge, so the falling edge is quiet.
    always @(negedge clk) begin
        chk("state", {29'd0, state}, m_mode);
        chk("busy", {31'd0, busy}, (m_mode == 1 || m_mode == 2));
        chk("done", {31'd0, done}, (m_mode == 3));
        chk("wr_en", {31'd0, wr_en}, (m_mode == 2) && data_en && !fifo_full && system_ready);
        chk("word_count", {16'd0, word_count}, m_cnt);
        chk("overflow", {31'd0, overflow}, m_ovf);
        chk("timed_out", {31'd0, timed_out}, m_to);
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rand_cycle();
        data_en      = ($urandom_range(0, 3) != 0);
        fifo_full    = ($urandom_range(0, 7) == 0);
        system_ready = ($urandom_range(0, 80) != 0);
        if ($urandom_range(0, 5) == 0) ext_trig = ~ext_trig;
        tick(1);
    endtask

    initial begin
        int n_wr;
        int len;
        model_reset();
        tick(2);
        chk("reset_state", {29'd0, state}, 0);
        chk("reset_wc", {16'd0, word_count}, 0);
        rst_n = 1'b1;
        system_ready = 1'b1;
        tick(2);

        // 1: immediate trigger, data every cycle
        ext_trig_en = 1'b0;
        data_en = 1'b1;
        arm = 1'b1;
        tick(3);
        chk("t1_arm_to_wait", {29'd0, state}, 1);
        tick(1);
        chk("t1_capture", {29'd0, state}, 2);
        for (int i = 0; i < N_WORDS; i++) begin
            chk("t1_beat", {31'd0, wr_en}, 1);
            tick(1);
        end
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_wc", {16'd0, word_count}, N_WORDS);
        chk("t1_no_wr_after", {31'd0, wr_en}, 0);
        arm = 1'b0;
        tick(3);
        chk("t1_idle", {29'd0, state}, 0);

        // 2: trigger already high before arm needs a fresh rising edge
        ext_trig_en = 1'b1;
        ext_trig = 1'b1;
        tick(3);
        arm = 1'b1;
        tick(3);
        chk("t2_wait", {29'd0, state}, 1);
        tick(5);
        chk("t2_held_no_trig", {29'd0, state}, 1);
        ext_trig = 1'b0;
        tick(3);
        ext_trig = 1'b1;
        tick(3);
        chk("t2_capture", {29'd0, state}, 2);
        chk("t2_timed_out", {31'd0, timed_out}, 0);
        tick(N_WORDS);
        chk("t2_done", {31'd0, done}, 1);
        arm = 1'b0;
        tick(3);

        // 3a: auto-trigger after exactly T_OUT cycles
        ext_trig = 1'b0;
        tick(3);
        arm = 1'b1;
        tick(3);
        chk("t3_wait", {29'd0, state}, 1);
        tick(T_OUT - 1);
        chk("t3_still_wait", {29'd0, state}, 1);
        tick(1);
        chk("t3_capture", {29'd0, state}, 2);
        chk("t3_timed_out", {31'd0, timed_out}, 1);
        tick(N_WORDS);
        arm = 1'b0;
        tick(3);

        // 3b: trigger edge lands on the timeout cycle; trigger wins
        arm = 1'b1;
        tick(3);
        tick(T_OUT - 3);
        ext_trig = 1'b1;
        tick(3);
        chk("t3b_capture", {29'd0, state}, 2);
        chk("t3b_timed_out", {31'd0, timed_out}, 0);
        tick(N_WORDS);
        arm = 1'b0;
        ext_trig = 1'b0;
        tick(3);

        // 4: FIFO full for three beats mid-capture
        ext_trig_en = 1'b0;
        arm = 1'b1;
        tick(4);
        n_wr = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            fifo_full = (i >= 3 && i < 6);
            #1;
            if (wr_en) n_wr++;
            tick(1);
        end
        fifo_full = 1'b0;
        chk("t4_total_beats", n_wr, N_WORDS);
        chk("t4_done", {31'd0, done}, 1);
        chk("t4_overflow", {31'd0, overflow}, 1);
        chk("t4_wc", {16'd0, word_count}, N_WORDS);
        arm = 1'b0;
        tick(3);

        // 5a: system_ready drop after four beats
        arm = 1'b1;
        tick(4);
        tick(4);
        chk("t5_wc4", {16'd0, word_count}, 4);
        system_ready = 1'b0;
        #1;
        chk("t5_wr_gated", {31'd0, wr_en}, 0);
        tick(1);
        chk("t5_idle", {29'd0, state}, 0);
        chk("t5_wc_hold", {16'd0, word_count}, 4);
        system_ready = 1'b1;
        tick(5);
        chk("t5_no_rearm", {29'd0, state}, 0);
        arm = 1'b0;
        tick(3);

        // 5b: asynchronous reset mid-capture
        arm = 1'b1;
        tick(4);
        tick(2);
        chk("t5b_capturing", {29'd0, state}, 2);
        rst_n = 1'b0;
        arm = 1'b0;
        #1;
        chk("t5b_rst_state", {29'd0, state}, 0);
        chk("t5b_rst_wr", {31'd0, wr_en}, 0);
        chk("t5b_rst_busy", {31'd0, busy}, 0);
        chk("t5b_rst_wc", {16'd0, word_count}, 0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        chk("t5b_stay_idle", {29'd0, state}, 0);
        arm = 1'b1;
        tick(3);
        chk("t5b_new_arm", {29'd0, state}, 1);
        tick(N_WORDS + 1);
        chk("t5b_done", {31'd0, done}, 1);
        arm = 1'b0;
        tick(3);

        // Randomized episodes against the model
        for (int ep = 0; ep < 40; ep++) begin
            ext_trig_en = $urandom_range(0, 1);
            arm = 1'b1;
            len = $urandom_range(4, 45);
            for (int c = 0; c < len; c++) rand_cycle();
            arm = 1'b0;
            len = $urandom_range(3, 8);
            for (int c = 0; c < len; c++) rand_cycle();
        end
        system_ready = 1'b1;
        data_en = 1'b0;
        fifo_full = 1'b0;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture sequencer between `dut_format` and `main_memory_top` in the ADC data-clock domain. It arms on an SPI-driven arm level and waits for the external trigger, or an auto-trigger timeout. It then gates exactly `CAPTURE_WORDS` BRAM write beats into the FIFO and reports done, overflow and progress. Nothing is written to main memory except inside a capture window.

## Interface
Parameters:
- `CAPTURE_WORDS`, 1024: BRAM write beats per capture; 1 ≤ value ≤ 2^`CNT_WIDTH`−1.
- `CNT_WIDTH`, 16: width of the beat counter and the timeout counter.
- `TRIG_TIMEOUT`, 0: data_clk cycles spent in WAIT_TRIG before auto-trigger; 0 disables auto-trigger.

Ports:
- `capture_ctrl_clk` in 1: data_clk from `capture`; the only clock.
- `capture_ctrl_reset_n` in 1: asynchronous, active-low reset (driven by `usb_master_rst_n`).
- `capture_ctrl_system_ready` in 1: data_clk_rdy; synchronous.
- `capture_ctrl_arm` in 1: arm level from the SPI register; asynchronous.
- `capture_ctrl_ext_trig` in 1: external trigger from SMA1; asynchronous.
- `capture_ctrl_ext_trig_en` in 1: quasi-static; 1 = wait for the trigger edge, 0 = immediate.
- `capture_ctrl_data_en` in 1: `dut_format_bram_data_en`; synchronous.
- `capture_ctrl_fifo_full` in 1: main-memory FIFO full, write-side; synchronous.
- `capture_ctrl_wr_en` out 1: gated BRAM write enable into main memory.
- `capture_ctrl_busy` out 1: high in WAIT_TRIG or CAPTURE.
- `capture_ctrl_done` out 1: high in DONE.
- `capture_ctrl_overflow` out 1: sticky; a beat was dropped on FIFO full.
- `capture_ctrl_timed_out` out 1: sticky; the capture started by timeout.
- `capture_ctrl_word_count` out `CNT_WIDTH`: beats written in the current capture.
- `capture_ctrl_state` out 3: state code; IDLE=0, WAIT_TRIG=1, CAPTURE=2, DONE=3.

## Operation
- Synchronizers:
  - `arm` and `ext_trig` each pass through 2 flops, followed by a registered previous-value flop.
  - `arm_rise`, `arm_fall` and `trig_rise` are single-cycle pulses.
- IDLE:
  - Moves to WAIT_TRIG on `arm_rise` && `system_ready`.
  - On that transition, clears `word_count`, `overflow`, `timed_out` and the timeout counter.
- WAIT_TRIG:
  - `ext_trig_en`=0: moves to CAPTURE on the next cycle.
  - `ext_trig_en`=1: moves to CAPTURE on `trig_rise`.
  - Timeout: when `TRIG_TIMEOUT`≠0 and the timeout counter reaches `TRIG_TIMEOUT`−1, moves to CAPTURE and sets `timed_out`.
  - If `trig_rise` and timeout occur in the same cycle, `trig_rise` wins and `timed_out` stays 0.
  - A trigger level that is already high on entry does not trigger; a rising edge is required.
- CAPTURE:
  - `wr_en` = `data_en` & (state==CAPTURE) & !`fifo_full`; combinational from registered state so data alignment is preserved.
  - Each `wr_en` increments `word_count`.
  - When `wr_en` occurs with `word_count`==`CAPTURE_WORDS`−1, the state moves to DONE and `word_count` ends at `CAPTURE_WORDS`.
  - `data_en` & `fifo_full`: the beat is dropped, `overflow` sets, the count holds, and the capture continues.
- DONE:
  - Holds while `arm` stays high.
  - `arm_fall` → IDLE.
  - A new capture requires a fresh arm rising edge.
- Abort: `system_ready`=0 in any state forces IDLE on the next edge and holds `wr_en` low. Counters and flags keep their values for readback.
- `arm_fall` during WAIT_TRIG or CAPTURE → IDLE (software abort); a partial `word_count` is retained.
- Reset values: state IDLE; `wr_en`, `busy`, `done`, `overflow`, `timed_out` = 0; `word_count` = 0; all synchronizer flops 0.
- Reset asserted mid-capture returns all outputs to reset values immediately (asynchronously). Release is clean; no capture starts without a new arm edge.
- `ext_trig_en` is sampled only in WAIT_TRIG. Changes in other states have no effect.

## Timing
- `arm` rise to state WAIT_TRIG: 3 clock edges (2 sync + 1 edge detect).
- `ext_trig` rise to state CAPTURE: 3 edges. The first `wr_en` is possible in the cycle the state reads CAPTURE.
- `ext_trig_en`=0: WAIT_TRIG lasts exactly 1 cycle.
- Timeout: CAPTURE is entered exactly `TRIG_TIMEOUT` cycles after entering WAIT_TRIG.
- `wr_en` has 0-cycle latency from `data_en` and `fifo_full`. `busy`, `done` and `state` are registered and change on the edge of the transition.
- The final beat asserts `wr_en`. `done` rises on the following edge, and no further `wr_en` occurs.

## Test plan
- `ext_trig_en`=0, `CAPTURE_WORDS`=8, `data_en` every cycle, arm rise → WAIT_TRIG after 3 edges. The next cycle enters CAPTURE with exactly 8 consecutive `wr_en`. `done`=1 and `word_count`=8 follow; `arm_fall` → IDLE.
- `ext_trig_en`=1, trigger held high before arm and then pulsed low→high → no capture until the rising edge. CAPTURE starts 3 edges after the edge; `timed_out`=0.
- `TRIG_TIMEOUT`=20, `ext_trig_en`=1, no trigger → CAPTURE exactly 20 cycles after WAIT_TRIG entry with `timed_out`=1. A repeat run with the trigger edge landing in the same cycle as the timeout gives `timed_out`=0.
- `fifo_full` high for 3 `data_en` beats mid-capture (`CAPTURE_WORDS`=8) → those 3 beats have no `wr_en`, `overflow`=1, and the total `wr_en` count is still 8 before `done`.
- `system_ready` dropped after 4 beats → IDLE next edge, no `wr_en`, `word_count` holds at 4. Asynchronous reset pulsed mid-CAPTURE → all outputs 0 immediately; after release, no capture until a new arm edge.
